uart_inst_loader: RTL and testbench
===================================

Name: uart_inst_loader

Overview:
- Serial program loader upstream of the instruction memory of the 8-bit single-cycle processor.
- Receives 8N1 UART bytes from the host on UART_RXD, frames them into 32-bit instruction words and writes them to consecutive instruction-memory addresses starting at 0.
- Holds the processor's PC/clock-enable stalled (o_cpu_hold) from the start of a load until a checksum-verified image is in place.
- Exposes state, word count and status flags for the LEDs and the LCD.

Parameters:
CLKS_PER_BIT, 434, iCLK cycles per UART bit (50 MHz / 115200 baud); legal range 4..65535
HEADER, 8'hA5, frame start byte
TIMEOUT_CYC, 5_000_000, max iCLK cycles between bytes inside a frame (100 ms at 50 MHz)

Ports:
iCLK  in  1  system clock (CLOCK_50)
iRST_N  in  1  asynchronous active-low reset
i_rxd  in  1  UART receive line, idle high, asynchronous to iCLK
o_mem_we  out  1  one-cycle write strobe to instruction memory
o_mem_addr  out  8  word address being written
o_mem_data  out  32  instruction word, first received byte = bits [31:24]
o_cpu_hold  out  1  1 = processor must not advance PC or write registers/memory
o_done  out  1  last frame loaded and checksum good
o_error  out  1  last frame aborted (framing, checksum or timeout)
o_state  out  3  loader FSM state encoding, for LEDs
o_word_cnt  out  8  words written in current/last frame

Behaviour:
- Reset values (asynchronous, iRST_N=0): all outputs 0, FSM in IDLE, RX in idle, i_rxd synchronizer flops set to 1.
- RX synchronizer: two flops on i_rxd; all RX logic uses the synchronized value (2-cycle input latency).
- RX falling-edge detect starts the bit timer. At CLKS_PER_BIT/2 (integer division) the line is resampled:
  - High: glitch; RX returns to idle and no byte is produced.
  - Low: valid start bit.
- Data bits are then sampled every CLKS_PER_BIT cycles, LSB first, 8 bits, followed by the stop bit.
- Stop bit low = framing error:
  - Byte discarded.
  - If the FSM is outside IDLE, it goes to ERR.
  - RX waits for the line to return high before re-arming.
- Good byte: internal rx_valid pulses for exactly 1 cycle, with rx_byte stable in that cycle.
- Loader FSM (o_state encoding):
  - IDLE(0): on rx_valid with byte==HEADER → COUNT; o_cpu_hold←1, o_done←0, o_error←0, o_word_cnt←0, checksum←0. Other bytes ignored.
  - COUNT(1): next byte is N, the number of words; N=0 means 256. → DATA, byte index←0.
  - DATA(2): each byte shifts into the word register MSB-first and is XORed into the checksum. On the 4th byte of a word:
    - Cycle after that rx_valid: o_mem_we=1 for one cycle, with o_mem_data = assembled word and o_mem_addr = o_word_cnt.
    - Cycle after the write: o_word_cnt increments (mod 256).
    - After word N is written → CHECK.
  - CHECK(3): next byte compared to the checksum (XOR of all 4N data bytes; header and N excluded).
    - Equal → DONE.
    - Else → ERR.
  - DONE(4): o_done=1, o_cpu_hold=0. Stays until a HEADER byte arrives, which re-enters COUNT exactly as from IDLE.
  - ERR(5): o_error=1, o_cpu_hold remains 1. A HEADER byte re-enters COUNT and clears o_error. Other bytes ignored.
- Timeout: an inter-byte counter is cleared on every rx_valid and counts only in COUNT/DATA/CHECK. Reaching TIMEOUT_CYC → ERR.
- Memory writes already issued before an error are not undone. o_cpu_hold=1 is the protection against running a partial image.
- o_mem_addr holds its last value when o_mem_we=0.
- A HEADER byte inside DATA is treated as data; it is not a resync.
- Reset mid-frame: immediate return to IDLE, o_cpu_hold=0. The processor then runs whatever memory holds; the host must re-send the frame.
- Unused states 6/7 → IDLE on the next clock.

Test Plan:
- CLKS_PER_BIT=8. Send A5 01 12 34 56 78 08 → one o_mem_we pulse with addr 0x00, data 0x12345678; o_word_cnt=1; o_done=1, o_error=0, o_cpu_hold=0, o_state=4.
- Send A5 02 00 00 00 01 00 00 00 02 03 → writes addr 0 = 0x00000001 then addr 1 = 0x00000002; checksum 0x03 accepted; done.
- Same frame with last byte 0xFF → both writes occur, then o_error=1, o_cpu_hold=1, o_state=5. Resending the good frame → done, error cleared.
- Send A5 02 then only 4 data bytes, with TIMEOUT_CYC=200 → 1 write, then ERR after 200 idle cycles; o_cpu_hold stays 1.
- Stimulus on i_rxd:
  - 2-cycle low glitch → no byte produced.
  - Byte with stop bit forced low during DATA → ERR.
  - In IDLE, bytes 00, FF, 5A → no state change.
- N=0 frame with 1024 incrementing-pattern bytes → 256 writes at addrs 0..255; o_word_cnt wraps to 0; DONE. Separately, assert iRST_N low mid-DATA → all outputs 0 immediately, o_state=0.

Source files
------------

// File: rtl/uart_inst_loader_if.sv
// Loader-side bus: UART receive line in, instruction-memory write port and status out.
// slave = loader, master = host/memory side.
interface uart_inst_loader_if;
  logic        i_rxd;
  logic        o_mem_we;
  logic [7:0]  o_mem_addr;
  logic [31:0] o_mem_data;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_error;
  logic [2:0]  o_state;
  logic [7:0]  o_word_cnt;

  modport slave (
    input  i_rxd,
    output o_mem_we, o_mem_addr, o_mem_data, o_cpu_hold, o_done, o_error, o_state, o_word_cnt
  );

  modport master (
    output i_rxd,
    input  o_mem_we, o_mem_addr, o_mem_data, o_cpu_hold, o_done, o_error, o_state, o_word_cnt
  );
endinterface

// File: rtl/uart_inst_loader.sv
// UART 8N1 program loader: frames bytes into 32-bit words, writes imem, holds the CPU until checksum ok.
// Latency: byte ready 2 sync cycles + ~9.5 bit times after start edge; write 1 cycle after 4th byte; no backpressure (host paces bytes).
module uart_inst_loader #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         TIMEOUT_CYC  = 5_000_000
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  uart_inst_loader_if.slave   bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } ld_state_t;

  logic        rxd_s1_q, rxd_s2_q, rxd_prev_q;
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] bit_tmr_q, bit_tmr_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_ferr_q, rx_ferr_d;

  ld_state_t   state_q, state_d;
  logic [8:0]  n_words_q, n_words_d;
  logic [8:0]  wr_tot_q, wr_tot_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic        in_frame;

  // Receiver: mid-bit sampling off the synchronized line
  always_comb begin
    rx_state_d = rx_state_q;
    bit_tmr_d  = bit_tmr_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        bit_tmr_d = '0;
        if (rxd_prev_q && !rxd_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (bit_tmr_q == 16'(HALF - 1)) begin
          bit_tmr_d  = '0;
          bit_idx_d  = '0;
          rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          bit_tmr_d = bit_tmr_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (bit_tmr_q == 16'(CLKS_PER_BIT - 1)) begin
          bit_tmr_d = '0;
          shreg_d   = {rxd_s2_q, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end else begin
          bit_tmr_d = bit_tmr_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (bit_tmr_q == 16'(CLKS_PER_BIT - 1)) begin
          bit_tmr_d = '0;
          if (rxd_s2_q) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shreg_q;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_d  = 1'b1;
            rx_state_d = RX_WAIT;
          end
        end else begin
          bit_tmr_d = bit_tmr_q + 16'd1;
        end
      end
      RX_WAIT: if (rxd_s2_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign in_frame = (state_q == ST_COUNT) || (state_q == ST_DATA) || (state_q == ST_CHECK);

  always_comb begin
    state_d    = state_q;
    n_words_d  = n_words_q;
    wr_tot_d   = wr_tot_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    word_cnt_d = word_cnt_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    to_cnt_d   = (rx_valid_q || !in_frame) ? '0 : to_cnt_q + TO_W'(1);

    // Count advances the cycle after the write so the write carries the pre-increment address
    if (mem_we_q) begin
      word_cnt_d = word_cnt_q + 8'd1;
      wr_tot_d   = wr_tot_q + 9'd1;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (rx_valid_q && rx_byte_q == HEADER) begin
          state_d    = ST_COUNT;
          word_cnt_d = '0;
          csum_d     = '0;
        end
      end
      ST_COUNT: begin
        if (rx_valid_q) begin
          n_words_d  = (rx_byte_q == 8'd0) ? 9'd256 : {1'b0, rx_byte_q};
          byte_idx_d = '0;
          wr_tot_d   = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_valid_q) begin
          word_d     = {word_q[23:0], rx_byte_q};
          csum_d     = csum_q ^ rx_byte_q;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            mem_we_d   = 1'b1;
            mem_data_d = {word_q[23:0], rx_byte_q};
            mem_addr_d = word_cnt_q;
          end
        end
        if (mem_we_q && (wr_tot_q + 9'd1 == n_words_q)) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (rx_valid_q) state_d = (rx_byte_q == csum_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rx_ferr_q && state_q != ST_IDLE) state_d = ST_ERR;
    if (in_frame && !rx_valid_q && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) state_d = ST_ERR;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      bit_tmr_q  <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      rx_ferr_q  <= 1'b0;
      state_q    <= ST_IDLE;
      n_words_q  <= '0;
      wr_tot_q   <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      word_cnt_q <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      rxd_s1_q   <= bus.i_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      rx_state_q <= rx_state_d;
      bit_tmr_q  <= bit_tmr_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      rx_ferr_q  <= rx_ferr_d;
      state_q    <= state_d;
      n_words_q  <= n_words_d;
      wr_tot_q   <= wr_tot_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      word_cnt_q <= word_cnt_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign bus.o_mem_we   = mem_we_q;
  assign bus.o_mem_addr = mem_addr_q;
  assign bus.o_mem_data = mem_data_q;
  assign bus.o_state    = state_q;
  assign bus.o_word_cnt = word_cnt_q;
  assign bus.o_done     = (state_q == ST_DONE);
  assign bus.o_error    = (state_q == ST_ERR);
  assign bus.o_cpu_hold = in_frame || (state_q == ST_ERR);

endmodule

// File: tb/tb_uart_inst_loader.sv
// Bench for uart_inst_loader: frame table plus hand sequences for glitch, framing, timeout, N=0 and reset.
module tb_uart_inst_loader;
  localparam int CPB = 8;
  localparam int TO  = 200;

  logic iCLK   = 1'b0;
  logic iRST_N = 1'b0;

  uart_inst_loader_if bus ();

  uart_inst_loader #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .bus   (bus)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  logic [7:0] tx_q[$];

  typedef struct {
    logic [7:0] b[12];
    int         len;
    logic [2:0] st;
    logic       dn, er, hd;
    logic [7:0] wc;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string pfx, input logic [2:0] st, input logic dn,
                              input logic er, input logic hd, input logic [7:0] wc);
    check({pfx, "_state"}, 32'(bus.o_state), 32'(st));
    check({pfx, "_done"},  32'(bus.o_done), 32'(dn));
    check({pfx, "_error"}, 32'(bus.o_error), 32'(er));
    check({pfx, "_hold"},  32'(bus.o_cpu_hold), 32'(hd));
    check({pfx, "_wcnt"},  32'(bus.o_word_cnt), 32'(wc));
  endtask

  // Scoreboard consumer: every write strobe must match the next expected word
  always @(negedge iCLK) begin
    wr_t e;
    if (iRST_N && bus.o_mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                 bus.o_mem_addr, bus.o_mem_data);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(bus.o_mem_addr), 32'(e.addr));
        check("write_data", bus.o_mem_data, e.data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.i_rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.i_rxd = b[i];
      idle(CPB);
    end
    bus.i_rxd = stop;
    idle(CPB);
    bus.i_rxd = 1'b1;
  endtask

  // Sends tx_q; expected writes are derived from the frame layout. glitch_at >= 0 inserts
  // a 2-cycle low pulse after that byte index.
  task automatic send_frame(input int glitch_at);
    int n;
    wr_t w;
    if (tx_q.size() >= 2 && tx_q[0] == 8'hA5) begin
      n = (tx_q[1] == 8'd0) ? 256 : int'(tx_q[1]);
      for (int k = 0; k < n; k++) begin
        if (2 + 4 * k + 3 < tx_q.size()) begin
          w.addr = 8'(k);
          w.data = {tx_q[2+4*k], tx_q[3+4*k], tx_q[4+4*k], tx_q[5+4*k]};
          exp_q.push_back(w);
        end
      end
    end
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i], 1'b1);
      if (i == glitch_at) begin
        idle(CPB);
        bus.i_rxd = 1'b0;
        idle(2);
        bus.i_rxd = 1'b1;
        idle(3 * CPB);
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_rxd = 1'b1;

    tbl[0].b = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[0].len = 7;  tbl[0].st = 3'd4; tbl[0].dn = 1; tbl[0].er = 0; tbl[0].hd = 0; tbl[0].wc = 8'd1;
    tbl[1].b = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03, 8'h00};
    tbl[1].len = 11; tbl[1].st = 3'd4; tbl[1].dn = 1; tbl[1].er = 0; tbl[1].hd = 0; tbl[1].wc = 8'd2;
    tbl[2] = tbl[1];
    tbl[2].b[10] = 8'hFF; tbl[2].st = 3'd5; tbl[2].dn = 0; tbl[2].er = 1; tbl[2].hd = 1;
    tbl[3] = tbl[1];

    // Reset state
    idle(3);
    check("rst_we",   32'(bus.o_mem_we), 32'd0);
    check("rst_addr", 32'(bus.o_mem_addr), 32'd0);
    check("rst_data", bus.o_mem_data, 32'd0);
    check_status("rst", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    iRST_N = 1'b1;
    idle(3);

    // Non-header bytes in IDLE
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    idle(20);
    check_status("idle_bytes", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    foreach (tbl[t]) begin
      tx_q.delete();
      for (int i = 0; i < tbl[t].len; i++) tx_q.push_back(tbl[t].b[i]);
      send_frame(-1);
      idle(20);
      check_status($sformatf("vec%0d", t), tbl[t].st, tbl[t].dn, tbl[t].er, tbl[t].hd, tbl[t].wc);
    end

    // Short low glitch after the header must not yield a byte
    tx_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_frame(0);
    idle(20);
    check_status("glitch", 3'd4, 1'b1, 1'b0, 1'b0, 8'd1);

    // Framing error inside DATA
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h3C, 1'b0);
    idle(3 * CPB);
    check_status("framing", 3'd5, 1'b0, 1'b1, 1'b1, 8'd0);

    // Truncated frame: one write, still DATA shortly after, ERR after timeout
    tx_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(-1);
    idle(20);
    check_status("pre_timeout", 3'd2, 1'b0, 1'b0, 1'b1, 8'd1);
    idle(TO);
    check_status("timeout", 3'd5, 1'b0, 1'b1, 1'b1, 8'd1);

    // N=0: 256 words, counter wraps, checksum of 4x(0..255) is 0
    tx_q.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h00);
    for (int i = 0; i < 1024; i++) tx_q.push_back(8'(i));
    tx_q.push_back(8'h00);
    send_frame(-1);
    idle(20);
    check_status("n256", 3'd4, 1'b1, 1'b0, 1'b0, 8'd0);

    // Asynchronous reset in the middle of DATA
    tx_q = '{8'hA5, 8'h01, 8'h12, 8'h34};
    send_frame(-1);
    idle(20);
    check("mid_state_pre", 32'(bus.o_state), 32'd2);
    #3;
    iRST_N = 1'b0;
    #1;
    check("midrst_we",   32'(bus.o_mem_we), 32'd0);
    check("midrst_addr", 32'(bus.o_mem_addr), 32'd0);
    check("midrst_data", bus.o_mem_data, 32'd0);
    check_status("midrst", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    idle(3);
    iRST_N = 1'b1;
    idle(5);

    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
